// File: rtl/mon_step_ctrl.sv
// Execution/monitor controller: PC-enable generation in step, run, burst and
// run-to-breakpoint modes, plus a freezable registered snapshot of a monitor channel.
module mon_step_ctrl #(
    parameter int DATA_W  = 16,
    parameter int N_CH    = 4,
    parameter int SEL_W   = 2,
    parameter int BURST_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step_tick,
    input  logic [1:0]             mode,
    input  logic [BURST_W-1:0]     burst_len,
    input  logic                   bp_en,
    input  logic [DATA_W-1:0]      bp_addr,
    input  logic [DATA_W-1:0]      pc,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]       ch_sel,
    input  logic                   freeze,
    output logic                   pc_enable,
    output logic                   halted,
    output logic                   busy,
    output logic [CNT_W-1:0]       step_count,
    output logic [DATA_W-1:0]      disp_word
);

    localparam logic [1:0] MODE_STEP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_BP    = 2'b11;
    localparam int         N_SEL      = 2 ** SEL_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        BURST  = 3'd2,
        RUN_BP = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t               state_reg;
    logic [BURST_W-1:0]   burst_cnt_reg;
    logic                 first_reg;
    logic                 halted_reg;
    logic                 busy_reg;
    logic [CNT_W-1:0]     step_count_reg;
    logic [DATA_W-1:0]    disp_reg;
    logic                 hit;
    logic                 pc_en_next;
    logic [DATA_W-1:0]    ch_pad [N_SEL];

    // The first RUN_BP cycle is exempt so a run can resume from the breakpoint PC.
    assign hit = (state_reg == RUN_BP) && bp_en && (pc == bp_addr) && !first_reg;

    always_comb begin
        pc_en_next = 1'b0;
        case (state_reg)
            IDLE:    pc_en_next = step_tick && (mode == MODE_STEP);
            RUN:     pc_en_next = 1'b1;
            BURST:   pc_en_next = 1'b1;
            RUN_BP:  pc_en_next = !hit;
            HALT:    pc_en_next = 1'b0;
            default: pc_en_next = 1'b0;
        endcase
    end

    assign pc_enable = pc_en_next && !reset;
    assign busy      = busy_reg && !reset;
    assign halted    = halted_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            first_reg     <= 1'b0;
            halted_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mode == MODE_RUN) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                    end else if (mode == MODE_BURST && step_tick && burst_len != '0) begin
                        state_reg     <= BURST;
                        burst_cnt_reg <= burst_len;
                        busy_reg      <= 1'b1;
                    end else if (mode == MODE_BP && step_tick) begin
                        state_reg <= RUN_BP;
                        first_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mode != MODE_RUN) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                BURST: begin
                    burst_cnt_reg <= burst_cnt_reg - 1'b1;
                    if (burst_cnt_reg <= BURST_W'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                RUN_BP: begin
                    first_reg <= 1'b0;
                    if (hit) begin
                        state_reg  <= HALT;
                        halted_reg <= 1'b1;
                        busy_reg   <= 1'b0;
                    end else if (mode != MODE_BP) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                HALT: begin
                    // A tick here only releases the halt; it never reaches pc_enable.
                    if (step_tick || mode != MODE_BP) begin
                        state_reg  <= IDLE;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    halted_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count_reg <= '0;
        end else if (pc_enable) begin
            step_count_reg <= step_count_reg + 1'b1;
        end
    end

    assign step_count = step_count_reg;

    // Unused select codes alias the last channel, so the mux index is always in range.
    generate
        for (genvar gi = 0; gi < N_SEL; gi++) begin : g_ch_pad
            if (gi < N_CH) begin : g_real
                assign ch_pad[gi] = ch_data[gi*DATA_W +: DATA_W];
            end else begin : g_alias
                assign ch_pad[gi] = ch_data[(N_CH-1)*DATA_W +: DATA_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_reg <= '0;
        end else if (!freeze) begin
            disp_reg <= ch_pad[ch_sel];
        end
    end

    assign disp_word = disp_reg;

endmodule

// File: tb/tb_mon_step_ctrl.sv
// Directed bench for mon_step_ctrl: step, burst, breakpoint, run/wrap, display and
// async reset, checked against a queue of expected values.
module tb_mon_step_ctrl;

    localparam int DATA_W  = 16;
    localparam int BURST_W = 8;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              step_tick = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [BURST_W-1:0] burst_len = '0;
    logic              bp_en = 1'b0;
    logic [DATA_W-1:0] bp_addr = '0;
    logic [DATA_W-1:0] pc;
    logic [4*DATA_W-1:0] ch_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic [3*DATA_W-1:0] ch_data3 = {16'h3333, 16'h2222, 16'h1111};
    logic [1:0]        ch_sel = 2'd0;
    logic              freeze = 1'b0;
    logic              pc_clr = 1'b1;

    logic              pc_enable, halted, busy;
    logic [CNT_W-1:0]  step_count;
    logic [DATA_W-1:0] disp_word;
    logic              pc_enable3, halted3, busy3;
    logic [CNT_W-1:0]  step_count3;
    logic [DATA_W-1:0] disp_word3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;
    exp_t sb[$];

    mon_step_ctrl #(.DATA_W(DATA_W), .N_CH(4), .SEL_W(2), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .step_tick(step_tick), .mode(mode), .burst_len(burst_len),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .ch_data(ch_data), .ch_sel(ch_sel),
        .freeze(freeze), .pc_enable(pc_enable), .halted(halted), .busy(busy),
        .step_count(step_count), .disp_word(disp_word)
    );

    mon_step_ctrl #(.DATA_W(DATA_W), .N_CH(3), .SEL_W(2), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .reset(reset), .step_tick(1'b0), .mode(2'b00), .burst_len(burst_len),
        .bp_en(1'b0), .bp_addr(bp_addr), .pc(pc), .ch_data(ch_data3), .ch_sel(ch_sel),
        .freeze(freeze), .pc_enable(pc_enable3), .halted(halted3), .busy(busy3),
        .step_count(step_count3), .disp_word(disp_word3)
    );

    always #5 clk = ~clk;

    // Stand-in for the core: the PC advances once per enabled cycle.
    always @(posedge clk) begin
        if (pc_clr) pc <= '0;
        else if (pc_enable) pc <= pc + 1'b1;
    end

    task automatic push(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic chk_now(input string tag, input logic [31:0] obs, input logic [31:0] value);
        push(tag, value);
        pop_chk(obs);
    endtask

    // Advance one clock; returns at the falling edge where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pc_clr = 1'b1;
        step_tick = 1'b0;
        cyc();
        reset = 1'b0;
        pc_clr = 1'b0;
        #1;
    endtask

    initial begin
        pc = '0;
        do_reset();
        chk_now("reset_pc_enable", 32'(pc_enable), 32'd0);
        chk_now("reset_busy", 32'(busy), 32'd0);
        chk_now("reset_halted", 32'(halted), 32'd0);
        chk_now("reset_step_count", 32'(step_count), 32'd0);
        chk_now("reset_disp_word", 32'(disp_word), 32'd0);

        // Single step: enable coincides with each tick.
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step_tick = 1'b1; #1;
            chk_now("step_en_tick", 32'(pc_enable), 32'd1);
            chk_now("step_busy", 32'(busy), 32'd0);
            cyc();
            step_tick = 1'b0; #1;
            chk_now("step_en_gap", 32'(pc_enable), 32'd0);
            cyc();
        end
        chk_now("step_count_3", 32'(step_count), 32'd3);

        // Burst of 5.
        mode = 2'b10; burst_len = 8'd5; step_tick = 1'b1; #1;
        chk_now("burst_tick_en", 32'(pc_enable), 32'd0);
        cyc();
        step_tick = 1'b0; burst_len = 8'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_now("burst_en", 32'(pc_enable), 32'd1);
            chk_now("burst_busy", 32'(busy), 32'd1);
            cyc();
        end
        #1;
        chk_now("burst_done_en", 32'(pc_enable), 32'd0);
        chk_now("burst_done_busy", 32'(busy), 32'd0);
        chk_now("burst_step_count", 32'(step_count), 32'd8);

        // Burst of 0 is ignored.
        burst_len = 8'd0; step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_now("burst0_en", 32'(pc_enable), 32'd0);
            chk_now("burst0_busy", 32'(busy), 32'd0);
            cyc();
        end
        chk_now("burst0_step_count", 32'(step_count), 32'd8);

        // Run to breakpoint at 0x0007.
        do_reset();
        mode = 2'b11; bp_en = 1'b1; bp_addr = 16'h0007;
        step_tick = 1'b1; #1;
        chk_now("bp_start_en", 32'(pc_enable), 32'd0);
        cyc();
        step_tick = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk_now("bp_pc", 32'(pc), 32'(i));
            chk_now("bp_run_en", 32'(pc_enable), 32'd1);
            cyc();
        end
        #1;
        chk_now("bp_hit_pc", 32'(pc), 32'h7);
        chk_now("bp_hit_en", 32'(pc_enable), 32'd0);
        cyc(); #1;
        chk_now("bp_halted", 32'(halted), 32'd1);
        chk_now("bp_halt_en", 32'(pc_enable), 32'd0);
        chk_now("bp_halt_busy", 32'(busy), 32'd0);
        step_tick = 1'b1; #1;
        chk_now("bp_release_en", 32'(pc_enable), 32'd0);
        cyc();
        step_tick = 1'b0; #1;
        chk_now("bp_released", 32'(halted), 32'd0);
        chk_now("bp_idle_en", 32'(pc_enable), 32'd0);
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0; #1;
        chk_now("bp_resume_en", 32'(pc_enable), 32'd1);
        cyc(); #1;
        chk_now("bp_resume_pc", 32'(pc), 32'h8);
        chk_now("bp_resume_en2", 32'(pc_enable), 32'd1);
        mode = 2'b00;
        cyc(); #1;
        chk_now("bp_exit_en", 32'(pc_enable), 32'd0);
        bp_en = 1'b0;

        // Free run for exactly 70000 enabled cycles: counter wraps.
        do_reset();
        mode = 2'b01; #1;
        chk_now("run_first_en", 32'(pc_enable), 32'd0);
        cyc();
        repeat (69999) cyc();
        mode = 2'b00; #1;
        chk_now("run_last_en", 32'(pc_enable), 32'd1);
        cyc(); #1;
        chk_now("run_stop_en", 32'(pc_enable), 32'd0);
        chk_now("run_wrap_count", 32'(step_count), 32'd4464);

        // Display capture with one-cycle latency, freeze and select clamp.
        freeze = 1'b0; ch_sel = 2'd2;
        push("disp_sel2", 32'h3333);
        cyc(); #1;
        pop_chk(32'(disp_word));
        freeze = 1'b1; ch_sel = 2'd0;
        push("disp_freeze", 32'h3333);
        push("disp_freeze_hold", 32'h3333);
        cyc(); #1;
        pop_chk(32'(disp_word));
        cyc(); #1;
        pop_chk(32'(disp_word));
        freeze = 1'b0;
        push("disp_sel0", 32'h1111);
        cyc(); #1;
        pop_chk(32'(disp_word));
        ch_sel = 2'd3;
        push("disp_sel3", 32'h4444);
        push("disp3_clamp", 32'h3333);
        cyc(); #1;
        pop_chk(32'(disp_word));
        pop_chk(32'(disp_word3));

        // Async reset in the middle of a burst.
        mode = 2'b10; burst_len = 8'd5; step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc(); cyc(); #1;
        chk_now("mid_burst_busy", 32'(busy), 32'd1);
        reset = 1'b1; #1;
        chk_now("arst_en", 32'(pc_enable), 32'd0);
        chk_now("arst_busy", 32'(busy), 32'd0);
        chk_now("arst_count", 32'(step_count), 32'd0);
        chk_now("arst_disp", 32'(disp_word), 32'd0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_now("post_rst_en", 32'(pc_enable), 32'd0);
            chk_now("post_rst_busy", 32'(busy), 32'd0);
            cyc();
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
